// File: rtl/l1_biu.sv
// L1 cache bus interface unit: single-word reads/writes, 128-word line fills and
// dirty-line write-backs over a simple req/ack/err memory bus.
module l1_biu #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_WORDS = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_req,
  input  logic                  write_through_req,
  input  logic                  read_line_req,
  input  logic                  write_line_req,
  input  logic [ADDR_WIDTH-1:0] pa,
  input  logic [DATA_WIDTH-1:0] wt_data,
  output logic [DATA_WIDTH-1:0] line_data,
  output logic [7:0]            addr_count,
  output logic                  line_write,
  output logic                  cache_entry_refill,
  output logic                  trans_rdy,
  output logic                  bus_error,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  input  logic                  mem_err
);

  localparam int LB_W = ADDR_WIDTH - 10;
  localparam int WA_W = ADDR_WIDTH - 3;
  localparam logic [6:0] LAST_IDX = 7'(LINE_WORDS - 1);

  typedef enum logic [3:0] {
    IDLE, SGL_RD, SGL_WR, FILL_REQ, FILL_WR, WB_RD, WB_REQ, RESP, ERR
  } state_t;

  state_t                  state_reg, state_next;
  logic [6:0]              word_idx_reg, word_idx_next;
  logic [LB_W-1:0]         line_base_reg, line_base_next;
  logic [WA_W-1:0]         word_addr_reg, word_addr_next;
  logic                    fill_op_reg, fill_op_next;
  logic [DATA_WIDTH-1:0]   line_data_reg, line_data_next;
  logic [DATA_WIDTH-1:0]   mem_wdata_reg, mem_wdata_next;

  // Byte-offset bits are irrelevant: every access is a whole aligned word.
  logic unused_pa_bits;
  assign unused_pa_bits = ^pa[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      word_idx_reg  <= '0;
      line_base_reg <= '0;
      word_addr_reg <= '0;
      fill_op_reg   <= 1'b0;
      line_data_reg <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      word_idx_reg  <= word_idx_next;
      line_base_reg <= line_base_next;
      word_addr_reg <= word_addr_next;
      fill_op_reg   <= fill_op_next;
      line_data_reg <= line_data_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    word_idx_next      = word_idx_reg;
    line_base_next     = line_base_reg;
    word_addr_next     = word_addr_reg;
    fill_op_next       = fill_op_reg;
    line_data_next     = line_data_reg;
    mem_wdata_next     = mem_wdata_reg;
    mem_req            = 1'b0;
    mem_we             = 1'b0;
    mem_addr           = '0;
    line_write         = 1'b0;
    trans_rdy          = 1'b0;
    cache_entry_refill = 1'b0;
    bus_error          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (write_line_req || read_line_req || write_through_req || read_req) begin
          line_base_next = pa[ADDR_WIDTH-1:10];
          word_addr_next = pa[ADDR_WIDTH-1:3];
          word_idx_next  = '0;
          fill_op_next   = 1'b0;
          if (write_line_req) begin
            state_next = WB_RD;
          end else if (read_line_req) begin
            state_next   = FILL_REQ;
            fill_op_next = 1'b1;
          end else if (write_through_req) begin
            state_next     = SGL_WR;
            mem_wdata_next = wt_data;
          end else begin
            state_next = SGL_RD;
          end
        end
      end
      SGL_RD: begin
        mem_req  = 1'b1;
        mem_addr = {word_addr_reg, 3'b000};
        if (mem_err) begin
          state_next = ERR;
        end else if (mem_ack) begin
          line_data_next = mem_rdata;
          state_next     = RESP;
        end
      end
      SGL_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {word_addr_reg, 3'b000};
        if (mem_err)      state_next = ERR;
        else if (mem_ack) state_next = RESP;
      end
      FILL_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {line_base_reg, word_idx_reg, 3'b000};
        if (mem_err) begin
          state_next = ERR;
        end else if (mem_ack) begin
          line_data_next = mem_rdata;
          state_next     = FILL_WR;
        end
      end
      FILL_WR: begin
        line_write = 1'b1;
        if (word_idx_reg == LAST_IDX) begin
          state_next = RESP;
        end else begin
          word_idx_next = word_idx_reg + 7'd1;
          state_next    = FILL_REQ;
        end
      end
      WB_RD: begin
        // The cache RAM has had this cycle to return the word at addr_count.
        mem_wdata_next = wt_data;
        state_next     = WB_REQ;
      end
      WB_REQ: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {line_base_reg, word_idx_reg, 3'b000};
        if (mem_err) begin
          state_next = ERR;
        end else if (mem_ack) begin
          if (word_idx_reg == LAST_IDX) begin
            state_next = RESP;
          end else begin
            word_idx_next = word_idx_reg + 7'd1;
            state_next    = WB_RD;
          end
        end
      end
      RESP: begin
        trans_rdy          = 1'b1;
        cache_entry_refill = fill_op_reg;
        state_next         = IDLE;
      end
      ERR: begin
        bus_error     = 1'b1;
        word_idx_next = '0;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign line_data  = line_data_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign addr_count = {word_idx_reg, 1'b0};

endmodule

// File: tb/tb_l1_biu.sv
// Randomized bench for l1_biu: a bus responder/monitor records every access and
// each operation is compared against an address/data model built from the op type.
module tb_l1_biu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_req = 1'b0, write_through_req = 1'b0;
  logic        read_line_req = 1'b0, write_line_req = 1'b0;
  logic [23:0] pa = '0;
  logic [63:0] wt_data;
  logic [63:0] line_data;
  logic [7:0]  addr_count;
  logic        line_write, cache_entry_refill, trans_rdy, bus_error;
  logic        mem_req, mem_we;
  logic [23:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_ack = 1'b0, mem_err = 1'b0;

  always #5 clk = ~clk;

  l1_biu dut (
    .clk(clk), .rst_n(rst_n),
    .read_req(read_req), .write_through_req(write_through_req),
    .read_line_req(read_line_req), .write_line_req(write_line_req),
    .pa(pa), .wt_data(wt_data), .line_data(line_data), .addr_count(addr_count),
    .line_write(line_write), .cache_entry_refill(cache_entry_refill),
    .trans_rdy(trans_rdy), .bus_error(bus_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
  );

  // Cache-side model: during a write-back the cache word at index i holds 0x100+i.
  logic        wb_mode = 1'b0;
  logic [63:0] wt_single = '0;
  assign wt_data = wb_mode ? (64'h100 + 64'(addr_count[7:1])) : wt_single;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_line_data"}, line_data, 64'h0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 64'h0);
    check_eq({tag, "_mem_addr"}, 64'(mem_addr), 64'h0);
    check_eq({tag, "_ctl"}, 64'({addr_count, line_write, cache_entry_refill, trans_rdy,
                                 bus_error, mem_req, mem_we}), 64'h0);
  endtask

  // Stimulus-owned op context
  int op_id = 0;
  int err_at = -1;

  // Monitor/responder-owned records
  int          seen_op = 0;
  int          cyc = 0;
  int          acc_n = 0;
  int          wait_cnt = 0;
  int          resp_cyc = -1, done_cyc = -1;
  int          tr_cnt = 0, refill_cnt = 0, both_cnt = 0, berr_cnt = 0;
  logic [63:0] line_data_done = '0;
  logic [23:0] acc_addr[$];
  bit          acc_we[$];
  logic [63:0] acc_wdata[$];
  logic [63:0] acc_rdata[$];
  logic [7:0]  lw_addr[$];
  logic [63:0] lw_data[$];

  initial begin : monitor
    logic [63:0] rd;
    forever begin
      @(negedge clk);
      cyc++;
      if (seen_op != op_id) begin
        seen_op = op_id;
        acc_addr.delete(); acc_we.delete(); acc_wdata.delete(); acc_rdata.delete();
        lw_addr.delete(); lw_data.delete();
        tr_cnt = 0; refill_cnt = 0; both_cnt = 0; berr_cnt = 0;
        resp_cyc = -1; done_cyc = -1; acc_n = 0;
        wait_cnt = $urandom_range(0, 2);
      end
      if (line_write) begin
        lw_addr.push_back(addr_count);
        lw_data.push_back(line_data);
      end
      if (trans_rdy) tr_cnt++;
      if (cache_entry_refill) refill_cnt++;
      if (trans_rdy && cache_entry_refill) both_cnt++;
      if (bus_error) berr_cnt++;
      if ((trans_rdy || bus_error) && done_cyc < 0) begin
        done_cyc = cyc;
        line_data_done = line_data;
      end
      mem_ack = 1'b0;
      mem_err = 1'b0;
      if (mem_req && rst_n) begin
        if (wait_cnt > 0) begin
          wait_cnt--;
        end else begin
          rd = {$urandom, $urandom};
          acc_addr.push_back(mem_addr);
          acc_we.push_back(mem_we);
          acc_wdata.push_back(mem_wdata);
          acc_rdata.push_back(rd);
          mem_rdata = rd;
          if (acc_n == err_at) begin
            mem_err = 1'b1;
            mem_ack = 1'($urandom_range(0, 1));
          end else begin
            mem_ack = 1'b1;
          end
          acc_n++;
          resp_cyc = cyc;
          wait_cnt = $urandom_range(0, 2);
        end
      end
    end
  end

  // reqs = {write_line, read_line, write_through, read}
  task automatic do_op(input logic [3:0] reqs, input logic [23:0] pa_v, input int err_v,
                       input bit noise);
    int kind, n_words, n_acc, n_lw, waited;
    bit is_err, line_op, is_write;
    logic [63:0] wt_v, exp_wd;
    logic [23:0] exp_addr;
    string tn;
    kind     = reqs[3] ? 3 : reqs[2] ? 2 : reqs[1] ? 1 : 0;
    line_op  = (kind >= 2);
    is_write = (kind == 1) || (kind == 3);
    n_words  = line_op ? 128 : 1;
    is_err   = (err_v >= 0) && (err_v < n_words);
    n_acc    = is_err ? err_v + 1 : n_words;
    n_lw     = (kind == 2) ? (is_err ? err_v : 128) : 0;
    wt_v     = {$urandom, $urandom};

    @(negedge clk);
    op_id++;
    err_at = err_v; wb_mode = (kind == 3); wt_single = wt_v; pa = pa_v;
    tn = $sformatf("op%0d", op_id);
    @(negedge clk);
    {write_line_req, read_line_req, write_through_req, read_req} = reqs;
    @(negedge clk);
    check_eq({tn, "_accept"}, 64'(mem_req), 64'(kind != 3));
    if (noise) begin
      {write_line_req, read_line_req, write_through_req, read_req} = 4'($urandom);
      pa = 24'($urandom);
      wt_single = {$urandom, $urandom};
      @(negedge clk);
    end
    {write_line_req, read_line_req, write_through_req, read_req} = 4'b0000;

    waited = 0;
    while ((tr_cnt + berr_cnt) == 0 && waited < 1500) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tn, "_timeout"}, 64'(waited < 1500), 64'h1);
    repeat (3) @(negedge clk);

    check_eq({tn, "_acc_count"}, 64'(acc_addr.size()), 64'(n_acc));
    for (int i = 0; i < n_acc && i < acc_addr.size(); i++) begin
      exp_addr = line_op ? ({pa_v[23:10], 10'b0} + 24'(8 * i)) : {pa_v[23:3], 3'b000};
      check_eq($sformatf("%s_addr%0d", tn, i), 64'(acc_addr[i]), 64'(exp_addr));
      check_eq($sformatf("%s_we%0d", tn, i), 64'(acc_we[i]), 64'(is_write));
      if (is_write) begin
        exp_wd = (kind == 1) ? wt_v : 64'(256 + i);
        check_eq($sformatf("%s_wdata%0d", tn, i), acc_wdata[i], exp_wd);
      end
    end
    check_eq({tn, "_lw_count"}, 64'(lw_addr.size()), 64'(n_lw));
    for (int i = 0; i < n_lw && i < lw_addr.size() && i < acc_rdata.size(); i++) begin
      check_eq($sformatf("%s_lw_idx%0d", tn, i), 64'(lw_addr[i]), 64'(2 * i));
      check_eq($sformatf("%s_lw_data%0d", tn, i), lw_data[i], acc_rdata[i]);
    end
    check_eq({tn, "_trans_rdy"}, 64'(tr_cnt), 64'(!is_err));
    check_eq({tn, "_bus_error"}, 64'(berr_cnt), 64'(is_err));
    check_eq({tn, "_refill"}, 64'(refill_cnt), 64'(kind == 2 && !is_err));
    check_eq({tn, "_refill_with_rdy"}, 64'(both_cnt), 64'(kind == 2 && !is_err));
    check_eq({tn, "_latency"}, 64'(done_cyc - resp_cyc), 64'((kind == 2 && !is_err) ? 2 : 1));
    if (kind == 0 && !is_err && acc_rdata.size() > 0)
      check_eq({tn, "_rd_data"}, line_data_done, acc_rdata[0]);
    $display("op %0d kind=%0d pa=0x%06h accesses=%0d line_writes=%0d rdy=%0d err=%0d",
             op_id, kind, pa_v, acc_addr.size(), lw_addr.size(), tr_cnt, berr_cnt);
  endtask

  task automatic reset_mid_writeback();
    int waited;
    @(negedge clk);
    op_id++;
    err_at = -1; wb_mode = 1'b1; pa = 24'h00A000;
    @(negedge clk);
    write_line_req = 1'b1;
    @(negedge clk);
    write_line_req = 1'b0;
    waited = 0;
    while (!(acc_addr.size() >= 60 && mem_req) && waited < 1500) begin
      @(negedge clk);
      waited++;
    end
    check_eq("rst_wb_reach_word60", 64'(waited < 1500), 64'h1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("rst_async");
    repeat (3) @(negedge clk);
    check_eq("rst_no_trans_rdy", 64'(tr_cnt), 64'h0);
    check_eq("rst_no_bus_error", 64'(berr_cnt), 64'h0);
    rst_n = 1'b1;
    $display("reset during write-back word 60 at pa=0x00A000");
  endtask

  initial begin
    logic [3:0] r;
    int e;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    check_all_zero("post_reset");

    do_op(4'b0001, 24'h001238, -1, 1'b0);
    do_op(4'b0100, 24'h012345, -1, 1'b0);
    do_op(4'b1000, 24'h004400, -1, 1'b0);
    do_op(4'b0100, 24'h0ABCDE, 5, 1'b0);
    do_op(4'b1100, 24'h033000, -1, 1'b1);
    do_op(4'b0010, 24'h0F0F0F, -1, 1'b1);
    do_op(4'b0001, 24'h123456, 0, 1'b0);
    reset_mid_writeback();
    do_op(4'b0001, 24'h00BEE8, -1, 1'b0);

    for (int n = 0; n < 22; n++) begin
      r = 4'($urandom_range(1, 15));
      e = -1;
      if ($urandom_range(0, 4) == 0)
        e = (r[3] || r[2]) ? int'($urandom_range(0, 127)) : 0;
      do_op(r, 24'($urandom), e, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l1_biu.md
L1_BIU -- requirements
Module: l1_biu

Interface
REQ-001 Parameter ADDR_WIDTH, 24, physical address width in bits.
REQ-002 Parameter DATA_WIDTH, 64, cache word and memory bus word width in bits.
REQ-003 Parameter LINE_WORDS, 128, words per cache line; fixed by the 8-bit addr_count, which holds the word index in bits [7:1].
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 read_req  input  1  level request for one uncached word read.
REQ-007 write_through_req  input  1  level request for one word write.
REQ-008 read_line_req  input  1  level request for a line fill.
REQ-009 write_line_req  input  1  level request for a dirty line write-back.
REQ-010 pa  input  ADDR_WIDTH  request physical address; stable while the request is high.
REQ-011 wt_data  input  DATA_WIDTH  write data: the single word, or the cache word addressed by addr_count during write-back.
REQ-012 line_data  output  DATA_WIDTH  registered memory read data.
REQ-013 addr_count  output  8  {word_idx[6:0], 1'b0}, the line word index to the cache.
REQ-014 line_write  output  1  one-cycle cache write strobe for line_data at addr_count.
REQ-015 cache_entry_refill  output  1  one-cycle pulse at the end of a successful fill.
REQ-016 trans_rdy  output  1  one-cycle completion pulse.
REQ-017 bus_error  output  1  one-cycle failure pulse.
REQ-018 mem_req / mem_we  output  1 / 1  memory request and write select; held until ack or err.
REQ-019 mem_addr  output  ADDR_WIDTH  memory word address; bits [2:0] are always 0.
REQ-020 mem_wdata  output  DATA_WIDTH  registered write data.
REQ-021 mem_rdata  input  DATA_WIDTH  read data, valid with mem_ack.
REQ-022 mem_ack / mem_err  input  1 / 1  single-cycle completion or error for the outstanding request.

Function
REQ-023 The FSM SHALL have the states IDLE, SGL_RD, SGL_WR, FILL_REQ, FILL_WR, WB_RD, WB_REQ, RESP and ERR.
REQ-024 In IDLE, the request priority SHALL be write_line_req, then read_line_req, then write_through_req, then read_req; on a request, pa[ADDR_WIDTH-1:10] SHALL be latched as the line base, pa[ADDR_WIDTH-1:3] as the word address, and word_idx SHALL be cleared to 0.
REQ-025 SGL_RD SHALL drive mem_req=1, mem_we=0 and mem_addr={word address, 3'b0}; on mem_ack it SHALL register mem_rdata into line_data and go to RESP.
REQ-026 On entry to SGL_WR, mem_wdata SHALL capture wt_data, and the state SHALL drive mem_req=1 and mem_we=1; on mem_ack it SHALL go to RESP.
REQ-027 FILL_REQ SHALL drive a read at mem_addr={line base, word_idx, 3'b0}; on mem_ack it SHALL register line_data and go to FILL_WR.
REQ-028 FILL_WR SHALL drive line_write=1 for exactly one cycle with addr_count={word_idx, 0}; if word_idx==LINE_WORDS-1 it SHALL go to RESP, otherwise it SHALL increment word_idx and go to FILL_REQ.
REQ-029 WB_RD SHALL present addr_count for one cycle to cover the cache RAM read latency; on the transition to WB_REQ, mem_wdata SHALL capture wt_data.
REQ-030 WB_REQ SHALL drive a write at {line base, word_idx, 3'b0}; on mem_ack it SHALL go to RESP if word_idx is the last index, otherwise it SHALL increment word_idx and go to WB_RD.
REQ-031 RESP SHALL pulse trans_rdy for one cycle, SHALL additionally pulse cache_entry_refill when the operation was a fill, and SHALL then go to IDLE.
REQ-032 If mem_err occurs in any request state, that state SHALL go to ERR with mem_req dropped next cycle; ERR SHALL pulse bus_error without trans_rdy, clear word_idx and go to IDLE.
REQ-033 If mem_ack and mem_err are high in the same cycle, mem_err SHALL win.
REQ-034 word_idx SHALL never wrap; the operation ends at LINE_WORDS-1.
REQ-035 Requests SHALL be sampled only in IDLE; changes to a request during a transfer SHALL be ignored.
REQ-036 Single-word latency SHALL be: trans_rdy asserts one cycle after the mem_ack cycle.

Reset
REQ-037 While rst_n is low, all registers SHALL clear immediately: state=IDLE, word_idx=0, and every output=0; a reset in mid-operation SHALL abandon the transfer without any trans_rdy or bus_error pulse.
REQ-038 The first request SHALL be accepted on the first rising clk edge after rst_n is deasserted.

Verification
REQ-039 read_req with pa=0x001238 and mem_ack one cycle later with rdata=0xDEADBEEF_00000001 -> mem_addr=0x001238, mem_we=0; one cycle after the ack, line_data=0xDEADBEEF_00000001 and trans_rdy=1.
REQ-040 read_line_req with pa=0x012345 and mem_ack on every request -> 128 reads at 0x012000 to 0x0123F8; 128 line_write pulses with addr_count 0x00, 0x02, ..., 0xFE; the final trans_rdy and cache_entry_refill pulse together.
REQ-041 write_line_req with pa=0x004400, where the model returns wt_data=0x100+index -> 128 writes to 0x004400 to 0x0047F8, each word's mem_wdata equal to 0x100+word_idx, then a single trans_rdy.
REQ-042 mem_err on word 5 of a fill -> exactly 5 line_write pulses, then bus_error=1 for one cycle, no trans_rdy, no cache_entry_refill, and state returns to IDLE.
REQ-043 rst_n pulled low during word 60 of a write-back -> mem_req=0 and all outputs=0 asynchronously; a new read_req after release completes normally.
REQ-044 write_line_req and read_line_req asserted together -> the write-back runs first.
